// File: rtl/tmds_channel_receiver.sv
// TMDS lane receiver: bit-serial deserialiser, control-token word alignment and
// 8b/10b TMDS decode. One serial bit is sampled on every sr_clk rising edge.
module tmds_channel_receiver #(
    parameter int unsigned LOCK_COUNT   = 4,
    parameter int unsigned MAX_DATA_RUN = 1024
) (
    input  logic       sr_clk,
    input  logic       n_rst,
    input  logic       serial_in,
    output logic       word_valid,
    output logic [7:0] data_out,
    output logic       de,
    output logic [1:0] ctrl,
    output logic       locked,
    output logic       lock_lost
);

    localparam logic [3:0]  LockCountW = 4'(LOCK_COUNT);
    localparam logic [11:0] MaxRunW    = 12'(MAX_DATA_RUN);

    typedef enum logic [1:0] {
        StSearch,
        StVerify,
        StLocked
    } state_e;

    state_e      state_q, state_d;
    // Oldest window bit is consumed in the same edge it would be shifted out, so only
    // bits 9:1 of the 10-bit window need to be stored.
    logic [9:1]  window_q;
    logic [9:0]  window_d;
    logic [3:0]  phase_q, phase_d;
    logic [3:0]  lock_cnt_q, lock_cnt_d;
    logic [11:0] run_cnt_q, run_cnt_d;
    logic        word_valid_q, word_valid_d;
    logic [7:0]  data_q, data_d;
    logic        de_q, de_d;
    logic [1:0]  ctrl_q, ctrl_d;
    logic        locked_q, locked_d;
    logic        lock_lost_q, lock_lost_d;

    logic        is_token;
    logic [1:0]  tok_code;
    logic [7:0]  w_inv;
    logic [7:0]  dec;
    logic        boundary;

    assign window_d = {serial_in, window_q[9:1]};
    assign boundary = (phase_q == 4'd9);

    always_comb begin
        is_token = 1'b1;
        tok_code = 2'b00;
        case (window_d)
            10'h354: tok_code = 2'b00;
            10'h0AB: tok_code = 2'b01;
            10'h154: tok_code = 2'b10;
            10'h2AB: tok_code = 2'b11;
            default: is_token = 1'b0;
        endcase
    end

    always_comb begin
        w_inv  = window_d[9] ? ~window_d[7:0] : window_d[7:0];
        dec    = 8'h00;
        dec[0] = w_inv[0];
        for (int i = 1; i < 8; i++) begin
            dec[i] = window_d[8] ? (w_inv[i] ^ w_inv[i-1]) : ~(w_inv[i] ^ w_inv[i-1]);
        end
    end

    always_comb begin
        state_d      = state_q;
        phase_d      = boundary ? 4'd0 : phase_q + 4'd1;
        lock_cnt_d   = lock_cnt_q;
        run_cnt_d    = run_cnt_q;
        word_valid_d = 1'b0;
        data_d       = data_q;
        de_d         = de_q;
        ctrl_d       = ctrl_q;
        locked_d     = locked_q;
        lock_lost_d  = 1'b0;

        case (state_q)
            StSearch: begin
                if (is_token) begin
                    phase_d    = 4'd0;
                    lock_cnt_d = 4'd1;
                    state_d    = StVerify;
                end
            end
            StVerify: begin
                if (boundary) begin
                    if (is_token) begin
                        lock_cnt_d = lock_cnt_q + 4'd1;
                        if (lock_cnt_q + 4'd1 == LockCountW) begin
                            state_d   = StLocked;
                            locked_d  = 1'b1;
                            run_cnt_d = 12'd0;
                        end
                    end else begin
                        lock_cnt_d = 4'd0;
                        state_d    = StSearch;
                    end
                end
            end
            StLocked: begin
                if (boundary) begin
                    if (is_token) begin
                        word_valid_d = 1'b1;
                        de_d         = 1'b0;
                        ctrl_d       = tok_code;
                        data_d       = 8'h00;
                        run_cnt_d    = 12'd0;
                    end else if (run_cnt_q + 12'd1 == MaxRunW) begin
                        // Too long without a token: assume slipped alignment, drop this word.
                        state_d     = StSearch;
                        locked_d    = 1'b0;
                        lock_lost_d = 1'b1;
                        run_cnt_d   = 12'd0;
                        lock_cnt_d  = 4'd0;
                    end else begin
                        word_valid_d = 1'b1;
                        de_d         = 1'b1;
                        ctrl_d       = 2'b00;
                        data_d       = dec;
                        run_cnt_d    = run_cnt_q + 12'd1;
                    end
                end
            end
            default: begin
                state_d = StSearch;
            end
        endcase
    end

    always_ff @(posedge sr_clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= StSearch;
            window_q     <= '0;
            phase_q      <= 4'd0;
            lock_cnt_q   <= 4'd0;
            run_cnt_q    <= 12'd0;
            word_valid_q <= 1'b0;
            data_q       <= 8'h00;
            de_q         <= 1'b0;
            ctrl_q       <= 2'b00;
            locked_q     <= 1'b0;
            lock_lost_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            window_q     <= window_d[9:1];
            phase_q      <= phase_d;
            lock_cnt_q   <= lock_cnt_d;
            run_cnt_q    <= run_cnt_d;
            word_valid_q <= word_valid_d;
            data_q       <= data_d;
            de_q         <= de_d;
            ctrl_q       <= ctrl_d;
            locked_q     <= locked_d;
            lock_lost_q  <= lock_lost_d;
        end
    end

    assign word_valid = word_valid_q;
    assign data_out   = data_q;
    assign de         = de_q;
    assign ctrl       = ctrl_q;
    assign locked     = locked_q;
    assign lock_lost  = lock_lost_q;

endmodule
